// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - two-requester round-robin arbiter in front of a combinational instruction ROM
module imem_fetch_arbiter #(
    parameter int AW = 5,
    parameter int DW = 59
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [7:0]    xact_cnt
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          busy_q, busy_d;
    logic [7:0]    xact_cnt_q, xact_cnt_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic          pick1;

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        rdata_d      = rdata_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        xact_cnt_d   = xact_cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        pick1        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie, requester 1 wins only if requester 0 was served last.
                    pick1      = req1 && (!req0 || !last_grant_q);
                    owner_d    = pick1;
                    mem_addr_d = pick1 ? addr1 : addr0;
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    state_d    = READ;
                end
            end
            READ: begin
                rdata_d      = mem_rdata;
                rvalid0_d    = !owner_q;
                rvalid1_d    = owner_q;
                last_grant_d = owner_q;
                xact_cnt_d   = xact_cnt_q + 8'd1;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            rdata_q      <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            busy_q       <= 1'b0;
            xact_cnt_q   <= 8'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            rdata_q      <= rdata_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            busy_q       <= busy_d;
            xact_cnt_q   <= xact_cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign busy     = busy_q;
    assign xact_cnt = xact_cnt_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - self-checking bench for imem_fetch_arbiter
module tb_imem_fetch_arbiter;
    localparam int AW = 5;
    localparam int DW = 59;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;
    logic [7:0]    xact_cnt;

    logic [DW-1:0] rom [32];
    assign mem_rdata = rom[mem_addr];

    imem_fetch_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .xact_cnt(xact_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: a grant at edge g yields read data at edge g+1
    // and the arbiter samples requests again from edge g+3 onward.
    int            n = 0;
    int            m_gedge = -10;
    int            m_owner = 0;
    int            m_last = 1;
    logic [AW-1:0] m_maddr = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [7:0]    m_cnt = 8'd0;
    logic [4:0]    e_flags;

    task automatic tick();
        @(posedge clk);
        n++;
        if (!rst) begin
            m_gedge = -10; m_last = 1; m_owner = 0;
            m_cnt = 8'd0; m_rdata = '0; m_maddr = '0;
        end else if (n >= m_gedge + 3 && (req0 || req1)) begin
            if (req0 && req1) m_owner = (m_last == 1) ? 0 : 1;
            else              m_owner = req1 ? 1 : 0;
            m_gedge = n;
            m_maddr = (m_owner == 1) ? addr1 : addr0;
        end else if (n == m_gedge + 1) begin
            m_rdata = rom[m_maddr];
            m_last  = m_owner;
            m_cnt   = m_cnt + 8'd1;
        end
        e_flags = {n == m_gedge && m_owner == 0, n == m_gedge && m_owner == 1,
                   n == m_gedge + 1 && m_owner == 0, n == m_gedge + 1 && m_owner == 1,
                   (n - m_gedge) < 2};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic fill_rom();
        logic [63:0] t;
        for (int i = 0; i < 32; i++) begin
            t = {$urandom(), $urandom()};
            rom[i] = t[DW-1:0];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        addr0 = 5'd7; addr1 = 5'd9;
        tick();
        tick();
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {gnt0, gnt1, rvalid0, rvalid1, busy});
        end
        total++;
        if (mem_addr !== '0 || rdata !== '0 || xact_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_data got addr=%0d rdata=%h cnt=%0d exp=0", mem_addr, rdata, xact_cnt);
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        rom[5] = 59'h1234;
        req0 = 1'b1; addr0 = 5'd5;
        tick();
        req0 = 1'b0;
        total++;
        if ({gnt0, gnt1, busy} !== 3'b101 || mem_addr !== 5'd5) begin
            bad++; $display("FAIL single_grant got gnt0/gnt1/busy=%b addr=%0d exp=101 addr=5", {gnt0, gnt1, busy}, mem_addr);
        end
        tick();
        total++;
        if ({gnt0, rvalid0, rvalid1} !== 3'b010 || rdata !== 59'h1234) begin
            bad++; $display("FAIL single_rvalid got g0/rv0/rv1=%b rdata=%h exp=010 rdata=1234", {gnt0, rvalid0, rvalid1}, rdata);
        end
        tick();
        total++;
        if (busy !== 1'b0 || rvalid0 !== 1'b0 || xact_cnt !== 8'd1) begin
            bad++; $display("FAIL single_done got busy=%b rv0=%b cnt=%0d exp busy=0 rv0=0 cnt=1", busy, rvalid0, xact_cnt);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 5'($urandom_range(0, 31)); addr1 = 5'($urandom_range(0, 31));
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
            if (rvalid0 || rvalid1) begin
                total++;
                if (order.size() == 0 || int'(rvalid1) != order[order.size()-1]) begin
                    bad++; $display("FAIL rr_owner cycle=%0d got rv0=%b rv1=%b exp matches last grant", c, rvalid0, rvalid1);
                end
            end
        end
        total++;
        if (order.size() != 4) begin
            bad++; $display("FAIL rr_count got=%0d exp=4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (order[i] != i % 2) begin
                    bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, order[i], i % 2);
                end
            end
        end
        total++;
        if (xact_cnt !== 8'd4) begin
            bad++; $display("FAIL rr_cnt got=%0d exp=4", xact_cnt);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_addr_change();
        do_reset();
        req1 = 1'b1; addr1 = 5'd31;
        tick();
        addr1 = 5'd0; req1 = 1'b0;
        tick();
        total++;
        if ({rvalid0, rvalid1} !== 2'b01 || rdata !== rom[31] || mem_addr !== 5'd31) begin
            bad++; $display("FAIL addr_change got rv=%b rdata=%h addr=%0d exp rv=01 rdata=%h addr=31", {rvalid0, rvalid1}, rdata, mem_addr, rom[31]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1'b1; addr0 = 5'($urandom_range(1, 31));
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0 || mem_addr !== '0 || rdata !== '0 || xact_cnt !== 8'd0) begin
            bad++; $display("FAIL mid_reset got flags=%b addr=%0d rdata=%h cnt=%0d exp all zero", {gnt0, gnt1, rvalid0, rvalid1, busy}, mem_addr, rdata, xact_cnt);
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b1; addr1 = 5'd17;
        tick();
        req1 = 1'b0;
        total++;
        if ({gnt0, gnt1} !== 2'b01 || mem_addr !== 5'd17) begin
            bad++; $display("FAIL mid_regrant got gnt=%b addr=%0d exp gnt=01 addr=17", {gnt0, gnt1}, mem_addr);
        end
        tick();
        total++;
        if ({rvalid0, rvalid1} !== 2'b01 || rdata !== rom[17] || xact_cnt !== 8'd1) begin
            bad++; $display("FAIL mid_rvalid got rv=%b rdata=%h cnt=%0d exp rv=01 rdata=%h cnt=1", {rvalid0, rvalid1}, rdata, xact_cnt, rom[17]);
        end
        tick();
    endtask

    task automatic test_wrap();
        int rv_seen = 0;
        int clash = 0;
        do_reset();
        for (int t = 0; t < 256; t++) begin
            if ($urandom_range(0, 1) == 1) begin req0 = 1'b0; req1 = 1'b1; end
            else                           begin req0 = 1'b1; req1 = 1'b0; end
            addr0 = 5'($urandom_range(0, 31)); addr1 = 5'($urandom_range(0, 31));
            for (int k = 0; k < 3; k++) begin
                tick();
                if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) clash++;
                if (rvalid0 || rvalid1) rv_seen++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (clash != 0) begin
            bad++; $display("FAIL wrap_collision got=%0d exp=0", clash);
        end
        total++;
        if (rv_seen != 256) begin
            bad++; $display("FAIL wrap_rvalids got=%0d exp=256", rv_seen);
        end
        total++;
        if (xact_cnt !== 8'd0 || xact_cnt !== m_cnt) begin
            bad++; $display("FAIL wrap_cnt got=%0d exp=0", xact_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 39) != 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            addr0 = 5'($urandom_range(0, 31));
            addr1 = 5'($urandom_range(0, 31));
            tick();
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== e_flags) begin
                bad++; $display("FAIL rand_flags cycle=%0d got=%b exp=%b", c, {gnt0, gnt1, rvalid0, rvalid1, busy}, e_flags);
            end
            total++;
            if (mem_addr !== m_maddr || rdata !== m_rdata || xact_cnt !== m_cnt) begin
                bad++; $display("FAIL rand_data cycle=%0d got addr=%0d rdata=%h cnt=%0d exp addr=%0d rdata=%h cnt=%0d",
                                c, mem_addr, rdata, xact_cnt, m_maddr, m_rdata, m_cnt);
            end
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        fill_rom();
        test_reset();
        test_single();
        test_round_robin();
        test_addr_change();
        test_reset_mid();
        test_wrap();
        fill_rom();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_arbiter.md
IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5, meaning instruction memory address width.
REQ-002 SHALL have parameter DW, default 59, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req0  input  1  requester 0 (CPU fetch) read request, level.
REQ-006 SHALL have port addr0  input  AW  requester 0 instruction address.
REQ-007 SHALL have port req1  input  1  requester 1 (debug/loader) read request, level.
REQ-008 SHALL have port addr1  input  AW  requester 1 instruction address.
REQ-009 SHALL have port mem_addr  output  AW  registered address to the combinational instruction ROM.
REQ-010 SHALL have port mem_rdata  input  DW  ROM read data, valid in the same cycle as mem_addr.
REQ-011 SHALL have port gnt0 / gnt1  output  1 each  one-cycle grant pulse.
REQ-012 SHALL have port rvalid0 / rvalid1  output  1 each  one-cycle read-data-valid pulse.
REQ-013 SHALL have port rdata  output  DW  captured instruction word, shared by both requesters.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port xact_cnt  output  8  completed-transaction counter.

Function
REQ-016 SHALL implement FSM states IDLE, READ, RESP; only IDLE samples req0/req1.
REQ-017 SHALL, in IDLE with no request, remain in IDLE with gnt/rvalid low.
REQ-018 SHALL, in IDLE with exactly one request, grant that requester.
REQ-019 SHALL, in IDLE with both requests, grant the requester not equal to last_grant (round-robin), guaranteeing no starvation.
REQ-020 SHALL, on the grant edge, load mem_addr from the winner's address, pulse that gnt for one cycle, record winner in owner, and enter READ.
REQ-021 SHALL, in READ, hold mem_addr; on the next edge capture mem_rdata into rdata, pulse rvalid[owner] for one cycle, set last_grant=owner, increment xact_cnt, and enter RESP.
REQ-022 SHALL, in RESP, return to IDLE on the next edge with rvalid low.
REQ-023 SHALL give latency: request sampled at edge E0 -> gnt high E0..E1 -> rvalid and rdata valid E1..E2 -> next grant no earlier than edge E3.
REQ-024 SHALL hold rdata and mem_addr unchanged between transactions.
REQ-025 SHALL complete a granted transaction even if the owner drops req after grant; rvalid still pulses.
REQ-026 SHALL treat a req held high through rvalid as a new request at the next IDLE sample (back-to-back fetch).
REQ-027 SHALL never assert gnt0 and gnt1, or rvalid0 and rvalid1, in the same cycle.
REQ-028 SHALL wrap xact_cnt from 255 to 0.
REQ-029 SHALL ignore address changes on addrX after the grant edge.

Reset
REQ-030 SHALL, when rst is low at a rising edge, force state=IDLE, mem_addr=0, rdata=0, gnt0=gnt1=0, rvalid0=rvalid1=0, busy=0, xact_cnt=0, last_grant=1 (req0 wins the first tie).
REQ-031 SHALL abort any in-flight transaction on reset with no rvalid pulse, regardless of state.
REQ-032 SHALL sample no request in the cycle rst is low; arbitration resumes at the first edge with rst high.

Verification
REQ-033 SHALL cover: single req0, addr0=5, ROM[5]=59'h1234 -> gnt0 at E0, rvalid0 and rdata=59'h1234 at E1, busy low after E2, xact_cnt=1.
REQ-034 SHALL cover: req0 and req1 held high continuously after reset -> grant order 0,1,0,1, each rvalid matching its owner, xact_cnt=4 after 12 cycles.
REQ-035 SHALL cover: req1 alone, addr1=31, then addr1 changed to 0 during READ -> rdata=ROM[31], rvalid1 only.
REQ-036 SHALL cover: rst low during READ -> next cycle all outputs zero, no rvalid, and a following req1 granted normally.
REQ-037 SHALL cover: 256 single-requester transactions -> xact_cnt wraps to 0 and no gnt/rvalid collision observed.
